// File: rtl/ahbl_sram_ws_pkg.sv
// Shared AHB-Lite encodings, data-phase state type and lane-enable helpers
// used by the wait-state SRAM slave.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } data_state_e;

  // Oversized transfers fall through to a full-word enable.
  function automatic logic [3:0] lane_enables(input logic [2:0] hsize, input logic [1:0] addr);
    logic [3:0] be;
    be = 4'b1111;
    case (hsize)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [2:0] hsize, input logic [1:0] addr);
    return (hsize > HSIZE_WORD) ||
           ((hsize == HSIZE_HALF) && addr[0]) ||
           ((hsize == HSIZE_WORD) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/ahbl_sram_ws_if.sv
// AHB-Lite slave-side bus bundle for ahbl_sram_ws.
interface ahbl_sram_ws_if;
  import ahbl_pkg::*;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HREADY, HSIZE, HWRITE, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HREADY, HSIZE, HWRITE, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahbl_sram_ws_sram.sv
// Behavioural single-port RAM: registered read and per-byte write enables;
// a behavioural model that can be swapped for a foundry macro.
module sram_1rw_be #(
  parameter int WORDS    = 16384,
  parameter int AW       = 14,
  parameter     HEX_FILE = ""
) (
  input  logic          clk,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ahbl_sram_ws.sv
// AHB-Lite SRAM slave with data-phase wait states and a one-entry posted
// write buffer; define AHBL_SRAM_ERR_EN for two-cycle ERROR on bad transfers.
module ahbl_sram_ws
  import ahbl_pkg::*;
#(
  parameter int SIZE        = 65536,
  parameter int WAIT_STATES = 0,
  parameter     HEX_FILE    = ""
) (
  input logic           HCLK,
  input logic           HRESET,
  ahbl_sram_ws_if.slave bus
);

  localparam int        AW = $clog2(SIZE);
  localparam int        WW = AW - 2;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  data_state_e   state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          is_write_q, is_write_d;
  logic [3:0]    lanes_q, lanes_d;
  logic [WW-1:0] waddr_q, waddr_d;
  logic          rd_first_q, rd_first_d;
  logic [31:0]   hold_q, hold_d;
  logic          buf_valid_q, buf_valid_d;
  logic [WW-1:0] buf_addr_q, buf_addr_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic [3:0]    buf_be_q, buf_be_d;

  logic          accept, start, xfer_err, hready_out;
  logic          sram_re, sram_we, buf_load;
  logic [WW-1:0] addr_word, sram_addr;
  logic [31:0]   sram_rdata, merged;
  logic          unused_bits;

  assign accept      = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign addr_word   = bus.HADDR[AW-1:2];
  assign unused_bits = ^{bus.HADDR[31:AW], bus.HTRANS[0]};

`ifdef AHBL_SRAM_ERR_EN
  assign xfer_err  = misaligned(bus.HSIZE, bus.HADDR[1:0]);
  assign bus.HRESP = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
  assign xfer_err  = 1'b0;
  assign bus.HRESP = HRESP_OKAY;
`endif

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    is_write_d = is_write_q;
    lanes_d    = lanes_q;
    waddr_d    = waddr_q;
    hready_out = 1'b1;
    start      = 1'b0;
    unique case (state_q)
      ST_IDLE: start = 1'b1;
      ST_DATA: begin
        if (wait_cnt_q != WS) begin
          hready_out = 1'b0;
          wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
          start = 1'b1;
        end
      end
      ST_ERR1: begin
        hready_out = 1'b0;
        state_d    = ST_ERR2;
      end
      ST_ERR2: start = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    // A completing phase either retires to IDLE or opens the next transfer.
    if (start) begin
      state_d = ST_IDLE;
      if (accept) begin
        state_d    = xfer_err ? ST_ERR1 : ST_DATA;
        wait_cnt_d = '0;
        is_write_d = bus.HWRITE;
        lanes_d    = lane_enables(bus.HSIZE, bus.HADDR[1:0]);
        waddr_d    = addr_word;
      end
    end
  end

  assign sram_re    = start & accept & ~bus.HWRITE & ~xfer_err;
  assign rd_first_d = sram_re;
  assign buf_load   = (state_q == ST_DATA) & hready_out & is_write_q;
  // Retirement is held off during reset so a pending write is truly dropped.
  assign sram_we    = buf_valid_q & ~sram_re & ~HRESET;
  assign sram_addr  = sram_re ? addr_word : buf_addr_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = (buf_valid_q && (buf_addr_q == waddr_q) && buf_be_q[i]) ?
                         buf_data_q[8*i +: 8] : sram_rdata[8*i +: 8];
    end
  end

  always_comb begin
    buf_valid_d = buf_valid_q & ~sram_we;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    buf_be_d    = buf_be_q;
    hold_d      = rd_first_q ? merged : hold_q;
    if (buf_load) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = waddr_q;
      buf_data_d  = bus.HWDATA;
      buf_be_d    = lanes_q;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      is_write_q  <= 1'b0;
      lanes_q     <= '0;
      waddr_q     <= '0;
      rd_first_q  <= 1'b0;
      hold_q      <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      buf_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      is_write_q  <= is_write_d;
      lanes_q     <= lanes_d;
      waddr_q     <= waddr_d;
      rd_first_q  <= rd_first_d;
      hold_q      <= hold_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      buf_be_q    <= buf_be_d;
    end
  end

  a_one_entry: assert property (@(posedge HCLK) disable iff (HRESET)
    !(buf_load && buf_valid_q && !sram_we));

  assign bus.HREADYOUT = hready_out;
  assign bus.HRDATA    = rd_first_q ? merged : hold_q;

  sram_1rw_be #(
    .WORDS    (SIZE / 4),
    .AW       (WW),
    .HEX_FILE (HEX_FILE)
  ) u_sram (
    .clk   (HCLK),
    .re    (sram_re),
    .we    (sram_we),
    .addr  (sram_addr),
    .be    (buf_be_q),
    .wdata (buf_data_q),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_ahbl_sram_ws.sv
// Directed bench for ahbl_sram_ws: a zero-wait and a three-wait instance
// driven through pipelined AHB-Lite cycles with hand-computed expectations.
module tb_ahbl_sram_ws;
  import ahbl_pkg::*;

  localparam int SIZE = 65536;

`ifdef AHBL_SRAM_ERR_EN
  localparam logic [31:0] HALF_EXP  = 32'hDEADBEEF;
  localparam logic [31:0] HALF_LOW  = 32'd1;
  localparam logic [31:0] HALF_RESP = 32'd1;
`else
  localparam logic [31:0] HALF_EXP  = 32'hCAFEBEEF;
  localparam logic [31:0] HALF_LOW  = 32'd0;
  localparam logic [31:0] HALF_RESP = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst0, rst3;
  int   n_checks, n_fail;
  logic [31:0] last_rd;
  logic [31:0] last_low;
  logic        last_resp, last_stable;

  always #5 clk = ~clk;

  ahbl_sram_ws_if b0();
  ahbl_sram_ws_if b3();

  assign b0.HREADY = b0.HREADYOUT;
  assign b3.HREADY = b3.HREADYOUT;

  ahbl_sram_ws #(.SIZE(SIZE), .WAIT_STATES(0), .HEX_FILE("")) u_dut0 (
    .HCLK(clk), .HRESET(rst0), .bus(b0)
  );

  ahbl_sram_ws #(.SIZE(SIZE), .WAIT_STATES(3), .HEX_FILE("")) u_dut3 (
    .HCLK(clk), .HRESET(rst3), .bus(b3)
  );

  function automatic logic [31:0] rd_of(input int sel);
    return (sel == 0) ? b0.HRDATA : b3.HRDATA;
  endfunction

  function automatic logic rdy_of(input int sel);
    return (sel == 0) ? b0.HREADYOUT : b3.HREADYOUT;
  endfunction

  function automatic logic resp_of(input int sel);
    return (sel == 0) ? b0.HRESP : b3.HRESP;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one address phase (go=0 means IDLE) plus the previous transfer's
  // write data, then waits for that previous data phase to complete.
  task automatic applyStimulus(input int sel, input logic go, input logic wr,
                               input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata);
    int guard;
    logic [31:0] first_rd;
    if (sel == 0) begin
      b0.HSEL = go; b0.HTRANS = go ? HTRANS_NONSEQ : HTRANS_IDLE; b0.HWRITE = wr;
      b0.HADDR = addr; b0.HSIZE = size; b0.HWDATA = wdata;
    end else begin
      b3.HSEL = go; b3.HTRANS = go ? HTRANS_NONSEQ : HTRANS_IDLE; b3.HWRITE = wr;
      b3.HADDR = addr; b3.HSIZE = size; b3.HWDATA = wdata;
    end
    last_low    = '0;
    last_stable = 1'b1;
    guard       = 0;
    @(negedge clk);
    first_rd = rd_of(sel);
    while (!rdy_of(sel) && guard < 40) begin
      last_low++;
      guard++;
      if (rd_of(sel) !== first_rd) last_stable = 1'b0;
      @(negedge clk);
    end
    if (guard >= 40) checkOutput("ready_timeout", {31'b0, rdy_of(sel)}, 32'd1);
    last_rd   = rd_of(sel);
    last_resp = resp_of(sel);
    if (last_rd !== first_rd) last_stable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input int sel, input logic [31:0] wdata);
    applyStimulus(sel, 1'b0, 1'b0, 32'h0, HSIZE_WORD, wdata);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst0 = 1'b1;
    rst3 = 1'b1;
    b0.HSEL = 0; b0.HTRANS = HTRANS_IDLE; b0.HWRITE = 0; b0.HADDR = 0; b0.HSIZE = HSIZE_WORD; b0.HWDATA = 0;
    b3.HSEL = 0; b3.HTRANS = HTRANS_IDLE; b3.HWRITE = 0; b3.HADDR = 0; b3.HSIZE = HSIZE_WORD; b3.HWDATA = 0;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready0", {31'b0, b0.HREADYOUT}, 32'd1);
    checkOutput("rst_resp0",  {31'b0, b0.HRESP}, 32'd0);
    checkOutput("rst_rdata0", b0.HRDATA, 32'h0);
    checkOutput("rst_ready3", {31'b0, b3.HREADYOUT}, 32'd1);
    checkOutput("rst_resp3",  {31'b0, b3.HRESP}, 32'd0);
    checkOutput("rst_rdata3", b3.HRDATA, 32'h0);
    @(posedge clk);
    #1;

    // Zero-wait write, idle, then read back.
    applyStimulus(0, 1, 1, 32'h10, HSIZE_WORD, 32'h0);
    idle_cycle(0, 32'hDEADBEEF);
    checkOutput("w0_wr_low", last_low, 32'd0);
    idle_cycle(0, 32'h0);
    applyStimulus(0, 1, 0, 32'h10, HSIZE_WORD, 32'h0);
    idle_cycle(0, 32'h0);
    checkOutput("w0_rd_data", last_rd, 32'hDEADBEEF);
    checkOutput("w0_rd_low", last_low, 32'd0);
    idle_cycle(0, 32'h0);
    checkOutput("w0_rd_hold", last_rd, 32'hDEADBEEF);

    // Back-to-back write then read of the same word.
    applyStimulus(0, 1, 1, 32'h20, HSIZE_WORD, 32'h0);
    applyStimulus(0, 1, 0, 32'h20, HSIZE_WORD, 32'h11223344);
    idle_cycle(0, 32'h0);
    checkOutput("fwd_word", last_rd, 32'h11223344);
    checkOutput("fwd_low", last_low, 32'd0);
    applyStimulus(0, 1, 1, 32'h22, HSIZE_BYTE, 32'h0);
    applyStimulus(0, 1, 0, 32'h20, HSIZE_WORD, 32'h55AA5555);
    idle_cycle(0, 32'h0);
    checkOutput("fwd_byte", last_rd, 32'h11AA3344);

    // Misaligned halfword write to 0x13.
    applyStimulus(0, 1, 1, 32'h13, HSIZE_HALF, 32'h0);
    idle_cycle(0, 32'hCAFE1234);
    checkOutput("half_low", last_low, HALF_LOW);
    checkOutput("half_resp", {31'b0, last_resp}, HALF_RESP);
    idle_cycle(0, 32'h0);
    applyStimulus(0, 1, 0, 32'h10, HSIZE_WORD, 32'h0);
    idle_cycle(0, 32'h0);
    checkOutput("half_data", last_rd, HALF_EXP);

    // Reset right after a write data phase discards the buffered write.
    applyStimulus(0, 1, 1, 32'h30, HSIZE_WORD, 32'h0);
    idle_cycle(0, 32'h01020304);
    idle_cycle(0, 32'h0);
    idle_cycle(0, 32'h0);
    applyStimulus(0, 1, 1, 32'h30, HSIZE_WORD, 32'h0);
    idle_cycle(0, 32'hFFFFFFFF);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_ready", {31'b0, b0.HREADYOUT}, 32'd1);
    checkOutput("rst_mid_rdata", b0.HRDATA, 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(0, 1, 0, 32'h30, HSIZE_WORD, 32'h0);
    idle_cycle(0, 32'h0);
    checkOutput("rst_mid_mem", last_rd, 32'h01020304);

    // Three wait states on write and read.
    applyStimulus(1, 1, 1, 32'h10, HSIZE_WORD, 32'h0);
    idle_cycle(1, 32'h5A5AA5A5);
    checkOutput("w3_wr_low", last_low, 32'd3);
    idle_cycle(1, 32'h0);
    applyStimulus(1, 1, 0, 32'h10, HSIZE_WORD, 32'h0);
    idle_cycle(1, 32'h0);
    checkOutput("w3_rd_low", last_low, 32'd3);
    checkOutput("w3_rd_data", last_rd, 32'h5A5AA5A5);
    checkOutput("w3_rd_stable", {31'b0, last_stable}, 32'd1);

    // Address aliasing modulo SIZE in both directions.
    applyStimulus(1, 1, 1, 32'h10 + SIZE, HSIZE_WORD, 32'h0);
    applyStimulus(1, 1, 0, 32'h10, HSIZE_WORD, 32'h0BADF00D);
    idle_cycle(1, 32'h0);
    checkOutput("alias_hi_wr", last_rd, 32'h0BADF00D);
    applyStimulus(1, 1, 1, 32'h10, HSIZE_WORD, 32'h0);
    idle_cycle(1, 32'h600DCAFE);
    idle_cycle(1, 32'h0);
    applyStimulus(1, 1, 0, 32'h10 + SIZE, HSIZE_WORD, 32'h0);
    idle_cycle(1, 32'h0);
    checkOutput("alias_hi_rd", last_rd, 32'h600DCAFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
